// File: rtl/fifo_ctrl_e0.sv
// Pointer and occupancy controller for the main FIFO: turns push/pop requests into
// RAM write/read enables and addresses, and derives full/empty/almost flags and a sticky error.
module fifo_ctrl_e0 #(
  parameter int DATA_SIZE       = 10,
  parameter int MAIN_QUEUE_SIZE = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [MAIN_QUEUE_SIZE:0]   almost_full_th,
  input  logic [MAIN_QUEUE_SIZE:0]   almost_empty_th,
  output logic                       write,
  output logic                       read,
  output logic [MAIN_QUEUE_SIZE-1:0] wr_ptr,
  output logic [MAIN_QUEUE_SIZE-1:0] rd_ptr,
  output logic [MAIN_QUEUE_SIZE:0]   fifo_count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       error
);

  localparam logic [MAIN_QUEUE_SIZE:0] DEPTH = {1'b1, {MAIN_QUEUE_SIZE{1'b0}}};

  if (DATA_SIZE < 1) begin : g_bad_data_size
    $error("fifo_ctrl_e0: DATA_SIZE must be at least 1");
  end

  logic pop_ok;
  logic push_ok;

  // Flags come from the occupancy alone, so full and empty never alias on equal pointers.
  always_comb begin
    full         = (fifo_count == DEPTH);
    empty        = (fifo_count == '0);
    almost_full  = (fifo_count >= almost_full_th);
    almost_empty = (fifo_count <= almost_empty_th);
    pop_ok       = pop && !empty;
    push_ok      = push && (!full || pop_ok);
    write        = push_ok;
    read         = pop_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      error      <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        fifo_count <= fifo_count - 1'b1;
      end
      // Any dropped request latches the error until the next reset.
      if ((push && !push_ok) || (pop && !pop_ok)) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_e0.sv
// Self-checking bench for fifo_ctrl_e0 at depth 4: an occupancy model checked every
// falling edge, plus directed scenarios with literal expectations.
module tb_fifo_ctrl_e0;

  localparam int QS    = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic [QS:0]   almost_full_th;
  logic [QS:0]   almost_empty_th;
  logic          write;
  logic          read;
  logic [QS-1:0] wr_ptr;
  logic [QS-1:0] rd_ptr;
  logic [QS:0]   fifo_count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          error;

  int total = 0;
  int bad   = 0;

  // Reference model state: plain integers, pointers kept modulo the depth.
  int  m_count = 0;
  int  m_wr    = 0;
  int  m_rd    = 0;
  bit  m_err   = 1'b0;

  fifo_ctrl_e0 #(.DATA_SIZE(10), .MAIN_QUEUE_SIZE(QS)) dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .pop             (pop),
    .almost_full_th  (almost_full_th),
    .almost_empty_th (almost_empty_th),
    .write           (write),
    .read            (read),
    .wr_ptr          (wr_ptr),
    .rd_ptr          (rd_ptr),
    .fifo_count      (fifo_count),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic q);
    @(posedge clk);
    #1;
    push = p;
    pop  = q;
    #1;
  endtask

  // Model advance: accept/reject decisions straight from occupancy arithmetic.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count = 0;
      m_wr    = 0;
      m_rd    = 0;
      m_err   = 1'b0;
    end else begin
      bit pok;
      bit wok;
      pok = pop && (m_count > 0);
      wok = push && ((m_count < DEPTH) || pok);
      if ((push && !wok) || (pop && !pok)) m_err = 1'b1;
      if (wok) m_wr = (m_wr + 1) % DEPTH;
      if (pok) m_rd = (m_rd + 1) % DEPTH;
      m_count = m_count + (wok ? 1 : 0) - (pok ? 1 : 0);
    end
  end

  always @(negedge clk) begin
    bit pok;
    bit wok;
    pok = pop && (m_count > 0);
    wok = push && ((m_count < DEPTH) || pok);
    checkOutput("cmp.write",        write,        wok);
    checkOutput("cmp.read",         read,         pok);
    checkOutput("cmp.wr_ptr",       wr_ptr,       m_wr);
    checkOutput("cmp.rd_ptr",       rd_ptr,       m_rd);
    checkOutput("cmp.fifo_count",   fifo_count,   m_count);
    checkOutput("cmp.full",         full,         m_count == DEPTH);
    checkOutput("cmp.empty",        empty,        m_count == 0);
    checkOutput("cmp.almost_full",  almost_full,  m_count >= int'(almost_full_th));
    checkOutput("cmp.almost_empty", almost_empty, m_count <= int'(almost_empty_th));
    checkOutput("cmp.error",        error,        m_err);
  end

  initial begin
    reset           = 1'b1;
    push            = 1'b0;
    pop             = 1'b0;
    almost_full_th  = 3'd3;
    almost_empty_th = 3'd1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("idle.empty",        empty,        1);
    checkOutput("idle.almost_empty", almost_empty, 1);
    checkOutput("idle.full",         full,         0);
    checkOutput("idle.count",        fifo_count,   0);
    checkOutput("idle.wr_ptr",       wr_ptr,       0);
    checkOutput("idle.rd_ptr",       rd_ptr,       0);
    checkOutput("idle.write",        write,        0);
    checkOutput("idle.read",         read,         0);
    checkOutput("idle.error",        error,        0);

    // Fill to the top
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("fill.write",        write,        1);
      checkOutput("fill.count",        fifo_count,   i);
      checkOutput("fill.almost_empty", almost_empty, i <= 1);
      checkOutput("fill.almost_full",  almost_full,  i >= 3);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("full.count",        fifo_count,   4);
    checkOutput("full.full",         full,         1);
    checkOutput("full.almost_full",  almost_full,  1);
    checkOutput("full.almost_empty", almost_empty, 0);
    checkOutput("full.wr_ptr",       wr_ptr,       0);

    // Overflow, then push+pop while full
    applyStimulus(1'b1, 1'b0);
    checkOutput("ovf.write", write, 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("ovf.error",    error,      1);
    checkOutput("ovf.count",    fifo_count, 4);
    checkOutput("fullpp.write", write,      1);
    checkOutput("fullpp.read",  read,       1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("fullpp.count",  fifo_count, 4);
    checkOutput("fullpp.wr_ptr", wr_ptr,     1);
    checkOutput("fullpp.rd_ptr", rd_ptr,     1);

    // Drain and underflow
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("drain.read",   read,       1);
      checkOutput("drain.rd_ptr", rd_ptr,     (1 + i) % 4);
      checkOutput("drain.count",  fifo_count, 4 - i);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("udf.read",   read,       0);
    checkOutput("udf.count",  fifo_count, 0);
    checkOutput("udf.empty",  empty,      1);
    checkOutput("udf.rd_ptr", rd_ptr,     1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("udf.error", error,      1);
    checkOutput("udf.count", fifo_count, 0);

    // Push+pop from empty after a reset
    @(posedge clk);
    #1 reset = 1'b1;
    #3 reset = 1'b0;
    applyStimulus(1'b1, 1'b1);
    checkOutput("emptypp.write", write, 1);
    checkOutput("emptypp.read",  read,  0);
    checkOutput("emptypp.error", error, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("emptypp.count", fifo_count, 1);
    checkOutput("emptypp.err1",  error,      1);
    checkOutput("emptypp.read2", read,       1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("emptypp.count0", fifo_count, 0);
    checkOutput("emptypp.empty",  empty,      1);

    // Asynchronous reset between edges with three words held
    repeat (3) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("async.pre_count", fifo_count, 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("async.count",        fifo_count,   0);
    checkOutput("async.empty",        empty,        1);
    checkOutput("async.almost_empty", almost_empty, 1);
    checkOutput("async.full",         full,         0);
    checkOutput("async.wr_ptr",       wr_ptr,       0);
    checkOutput("async.rd_ptr",       rd_ptr,       0);
    checkOutput("async.error",        error,        0);
    #1 reset = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("async.write",    write,  1);
    checkOutput("async.wr_ptr0",  wr_ptr, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("async.wr_ptr1",  wr_ptr,     1);
    checkOutput("async.count1",   fifo_count, 1);

    // Threshold extremes follow combinationally
    almost_full_th  = 3'd0;
    almost_empty_th = 3'd4;
    #1;
    checkOutput("th.almost_full",  almost_full,  1);
    checkOutput("th.almost_empty", almost_empty, 1);
    almost_full_th  = 3'd2;
    almost_empty_th = 3'd0;
    #1;
    checkOutput("th.almost_full2",  almost_full,  0);
    checkOutput("th.almost_empty2", almost_empty, 0);
    almost_full_th  = 3'd3;
    almost_empty_th = 3'd1;
    repeat (2) applyStimulus(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
